// File: rtl/sc_ballshifter_jug2_pkg.sv
// Shared state encodings and field positions for the player-2 pong half.
// Used by the ball shifter and the player-2 side comparator.
package sc_ballshifter_jug2_pkg;

  localparam logic [1:0] SC_STATE_IDLE  = 2'd0;
  localparam logic [1:0] SC_STATE_RIGHT = 2'd1;
  localparam logic [1:0] SC_STATE_LEFT  = 2'd2;

  localparam logic [7:0] SC_POS_ENTRY  = 8'b00001000;
  localparam logic [7:0] SC_POS_PADDLE = 8'b00000001;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Ball-step prescaler: counts 0..div-1, tick on terminal count.
// Ports: clk_i, rst_ni, clr_i (sync clear), div_i (divisor), tick_o.
module sc_tick_prescaler #(
  parameter int W = 25
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // >= keeps the counter bounded if the divisor shrinks under it
  assign tick_o = (cnt_q >= (div_i - W'(1)));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sc_ballshifter_jug2.sv
// Player-2 ball position register: serve, step, paddle hit, miss, handoff.
// Ports: CLOCK_50, RESET_InLow (async), entra_InHigh, boton_InLow,
//        data_OutBUS (one-hot), miss_OutHigh, handoff_OutHigh.
// Option: SC_BALLSHIFTER_JUG2_SPEEDUP_EN shortens the step on each hit.
module sc_ballshifter_jug2
  import sc_ballshifter_jug2_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int TICK_DIV  = 25000000,
  parameter int TICK_MIN  = 6250000
) (
  input  logic                 SC_BALLSHIFTER_JUG2_CLOCK_50,
  input  logic                 SC_BALLSHIFTER_JUG2_RESET_InLow,
  input  logic                 SC_BALLSHIFTER_JUG2_entra_InHigh,
  input  logic                 SC_BALLSHIFTER_JUG2_boton_InLow,
  output logic [DATAWIDTH-1:0] SC_BALLSHIFTER_JUG2_data_OutBUS,
  output logic                 SC_BALLSHIFTER_JUG2_miss_OutHigh,
  output logic                 SC_BALLSHIFTER_JUG2_handoff_OutHigh
);

  // wide enough for whichever divisor bound is larger
  localparam int DMAX = (TICK_DIV > TICK_MIN) ? TICK_DIV : TICK_MIN;
  localparam int DIVW = $clog2(DMAX + 1);

  localparam logic [DATAWIDTH-1:0] POS_ENTRY  = DATAWIDTH'(SC_POS_ENTRY);
  localparam logic [DATAWIDTH-1:0] POS_PADDLE = DATAWIDTH'(SC_POS_PADDLE);

  logic                 clk;
  logic                 rst_n;
  logic                 entra;
  logic                 boton_n;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [DATAWIDTH-1:0] data_q;
  logic [DATAWIDTH-1:0] data_d;
  logic                 miss_q;
  logic                 miss_d;
  logic                 ho_q;
  logic                 ho_d;
  logic                 tick;
  logic                 clr;
  logic [DIVW-1:0]      div;

  assign clk     = SC_BALLSHIFTER_JUG2_CLOCK_50;
  assign rst_n   = SC_BALLSHIFTER_JUG2_RESET_InLow;
  assign entra   = SC_BALLSHIFTER_JUG2_entra_InHigh;
  assign boton_n = SC_BALLSHIFTER_JUG2_boton_InLow;

`ifdef SC_BALLSHIFTER_JUG2_SPEEDUP_EN
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] div_d;
  logic [DIVW-1:0] div_fast;
  logic            hit;

  assign hit = (state_q == SC_STATE_RIGHT) &&
               (data_q == POS_PADDLE) && !boton_n;
  assign div_fast = div_q - (div_q >> 2);

  always_comb begin
    div_d = div_q;
    if (hit) begin
      div_d = (div_fast > DIVW'(TICK_MIN)) ? div_fast
                                           : DIVW'(TICK_MIN);
    end else if (miss_d) begin
      div_d = DIVW'(TICK_DIV);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= DIVW'(TICK_DIV);
    else        div_q <= div_d;
  end

  assign div = div_q;
`else
  assign div = DIVW'(TICK_DIV);
`endif

  // every state entry restarts the step period
  assign clr = (state_d != state_q);

  sc_tick_prescaler #(
    .W (DIVW)
  ) u_presc (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .div_i  (div),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    miss_d  = 1'b0;
    ho_d    = 1'b0;
    unique case (state_q)
      SC_STATE_IDLE: begin
        data_d = '0;
        if (entra) begin
          data_d  = POS_ENTRY;
          state_d = SC_STATE_RIGHT;
        end
      end
      SC_STATE_RIGHT: begin
        if (data_q == POS_PADDLE) begin
          // hit outranks a coincident tick
          if (!boton_n) begin
            state_d = SC_STATE_LEFT;
          end else if (tick) begin
            data_d  = '0;
            miss_d  = 1'b1;
            state_d = SC_STATE_IDLE;
          end
        end else if (tick) begin
          data_d = data_q >> 1;
        end
      end
      SC_STATE_LEFT: begin
        if (tick) begin
          if (data_q == POS_ENTRY) begin
            data_d  = '0;
            ho_d    = 1'b1;
            state_d = SC_STATE_IDLE;
          end else begin
            data_d = data_q << 1;
          end
        end
      end
      default: begin
        data_d  = '0;
        state_d = SC_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SC_STATE_IDLE;
      data_q  <= '0;
      miss_q  <= 1'b0;
      ho_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      miss_q  <= miss_d;
      ho_q    <= ho_d;
    end
  end

  assign SC_BALLSHIFTER_JUG2_data_OutBUS     = data_q;
  assign SC_BALLSHIFTER_JUG2_miss_OutHigh    = miss_q;
  assign SC_BALLSHIFTER_JUG2_handoff_OutHigh = ho_q;

endmodule

// File: tb/tb_sc_ballshifter_jug2.sv
// Scoreboard bench for sc_ballshifter_jug2: timestamped output events.
// Optional: SC_BALLSHIFTER_JUG2_SPEEDUP_EN selects TICK_DIV=8/TICK_MIN=4.
module tb_sc_ballshifter_jug2;

`ifdef SC_BALLSHIFTER_JUG2_SPEEDUP_EN
  localparam int TD = 8;
  localparam int TM = 4;
`else
  localparam int TD = 4;
  localparam int TM = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       entra = 1'b0;
  logic       btn_n = 1'b1;
  logic [7:0] data;
  logic       miss;
  logic       ho;

  always #5 clk = ~clk;

  sc_ballshifter_jug2 #(
    .DATAWIDTH (8),
    .TICK_DIV  (TD),
    .TICK_MIN  (TM)
  ) dut (
    .SC_BALLSHIFTER_JUG2_CLOCK_50        (clk),
    .SC_BALLSHIFTER_JUG2_RESET_InLow     (rst_n),
    .SC_BALLSHIFTER_JUG2_entra_InHigh    (entra),
    .SC_BALLSHIFTER_JUG2_boton_InLow     (btn_n),
    .SC_BALLSHIFTER_JUG2_data_OutBUS     (data),
    .SC_BALLSHIFTER_JUG2_miss_OutHigh    (miss),
    .SC_BALLSHIFTER_JUG2_handoff_OutHigh (ho)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       m;
    logic       h;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  bit  armed = 1'b0;
  logic [9:0] prev_o;
  logic [9:0] cur_o;
  ev_t e;

  // reference: ball as bit index + absolute cycle of next step
  typedef enum {M_IDLE, M_TOWARD, M_AWAY} mode_e;
  mode_e      mode = M_IDLE;
  int         pos = 0;
  int         nxt = 0;
  int         div = TD;
  logic [9:0] exp_o = '0;

  task automatic push_if_changed(logic [9:0] n, int k);
    if (n !== exp_o) q.push_back('{k, n[9:2], n[1], n[0]});
    exp_o = n;
  endtask

  task automatic model_edge(bit en, bit press);
    int k;
    bit m;
    bit h;
    logic [7:0] d;
    k = cyc + 1;
    m = 1'b0;
    h = 1'b0;
    case (mode)
      M_IDLE: begin
        if (en) begin
          mode = M_TOWARD;
          pos  = 3;
          nxt  = k + div;
        end
      end
      M_TOWARD: begin
        if (pos == 0 && press) begin
          mode = M_AWAY;
`ifdef SC_BALLSHIFTER_JUG2_SPEEDUP_EN
          div = (div - div / 4 > TM) ? div - div / 4 : TM;
`endif
          nxt = k + div;
        end else if (k == nxt) begin
          if (pos > 0) begin
            pos = pos - 1;
            nxt = k + div;
          end else begin
            mode = M_IDLE;
            m    = 1'b1;
            div  = TD;
          end
        end
      end
      M_AWAY: begin
        if (k == nxt) begin
          if (pos < 3) begin
            pos = pos + 1;
            nxt = k + div;
          end else begin
            mode = M_IDLE;
            h    = 1'b1;
          end
        end
      end
      default: mode = M_IDLE;
    endcase
    d = (mode == M_IDLE) ? 8'h00 : 8'(1 << pos);
    push_if_changed({d, m, h}, k);
  endtask

  task automatic step(bit en, bit press);
    @(negedge clk);
    #2;
    entra = en;
    btn_n = ~press;
    model_edge(en, press);
  endtask

  task automatic do_reset(int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    entra = 1'b0;
    btn_n = 1'b1;
    #1;
    checks++;
    if ({data, miss, ho} !== 10'd0) begin
      failures++;
      $display("FAIL async_reset got data=%h miss=%b ho=%b want 00 0 0",
               data, miss, ho);
    end
    mode = M_IDLE;
    div  = TD;
    push_if_changed(10'd0, cyc + 1);
    repeat (hold) @(negedge clk);
    #2;
    rst_n = 1'b1;
    model_edge(1'b0, 1'b0);
  endtask

  task automatic serve_and_miss();
    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && mode != M_IDLE; i++) step(1'b0, 1'b0);
  endtask

  task automatic serve_and_hit();
    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && !(mode == M_TOWARD && pos == 0); i++)
      step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 200 && mode != M_IDLE; i++) step(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cur_o = {data, miss, ho};
      if (cur_o !== prev_o) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got data=%h miss=%b ho=%b",
                   cyc, data, miss, ho);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || {e.d, e.m, e.h} !== cur_o) begin
            failures++;
            $display("FAIL event cyc=%0d data=%h miss=%b ho=%b want cyc=%0d data=%h miss=%b ho=%b",
                     cyc, data, miss, ho, e.cyc, e.d, e.m, e.h);
          end
        end
        prev_o = cur_o;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({data, miss, ho} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state got data=%h miss=%b ho=%b want 00 0 0",
               data, miss, ho);
    end
    prev_o = {data, miss, ho};
    armed  = 1'b1;
    #1 rst_n = 1'b1;

    serve_and_miss();
    serve_and_hit();

    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && pos != 2; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && mode != M_IDLE; i++) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && pos != 1; i++) step(1'b0, 1'b0);
    do_reset(2);
    repeat (12) step(1'b0, 1'b0);

    repeat (4) serve_and_hit();
    serve_and_miss();
    serve_and_hit();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0)
        do_reset(int'($urandom_range(1, 3)));
      else
        step($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end

    repeat (3) step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
